com_bus_arbiter: RTL and testbench
==================================

COM_BUS_ARBITER -- requirements
Module: com_bus_arbiter

Interface
REQ-001 Parameter CORES, default 4: number of cores; the block SHALL support 1 to 8.
REQ-002 Parameter NPROC, default 2*CORES: processor-side requesters, IL and DL per core; index 2c = IL, 2c+1 = DL of core c.
REQ-003 Parameter NSNOOP, default CORES+1: snoop requesters; index CORES = lower-level memory.
REQ-004 Parameter MAX_HOLD, default 64: processor grant hold limit in cycles, minimum 2.
REQ-005 clk  in  1  single clock; all state on posedge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 Com_Bus_Req_proc  in  NPROC  common-bus request per IL/DL cache.
REQ-008 Com_Bus_Gnt_proc  out  NPROC  one-hot-or-zero processor grant.
REQ-009 Com_Bus_Req_snoop  in  CORES  snoop-bus request per core.
REQ-010 Mem_snoop_req  in  1  memory snoop-bus request.
REQ-011 Com_Bus_Gnt_snoop  out  CORES  per-core snoop grant.
REQ-012 Mem_snoop_gnt  out  1  memory snoop grant.
REQ-013 Gnt_id_proc  out  $clog2(NPROC)  index of the current processor grant; 0 when idle.
REQ-014 Bus_busy  out  1  high while any processor grant is active.
REQ-015 Hold_timeout  out  1  sticky error flag.

Function
REQ-016 FSM states SHALL be IDLE, PROC_GNT and SNOOP_GNT; all grants SHALL be registered.
REQ-017 IDLE: if any Com_Bus_Req_proc bit is high, the round-robin winner SHALL be granted at the next edge, a 1-cycle latency, and the FSM SHALL enter PROC_GNT.
REQ-018 Processor round-robin: search SHALL start at pointer p and wrap from NPROC-1 to 0; after a grant to index w is released, p SHALL become (w+1) mod NPROC.
REQ-019 PROC_GNT: the grant SHALL be held while the granted request stays high; requests from other requesters SHALL NOT change the grant.
REQ-020 Release: when the granted request is low at an edge, the grant SHALL drop at that edge and the FSM SHALL return to IDLE; the next grant SHALL come no earlier than the following edge, giving one bubble cycle.
REQ-021 PROC_GNT: if any snoop request (cores or memory) is high, the snoop round-robin winner over NSNOOP requesters SHALL be granted at the next edge and the FSM SHALL enter SNOOP_GNT; the snoop pointer SHALL follow the REQ-018 rules.
REQ-022 Snoop requests SHALL be ignored in IDLE; no snoop grant SHALL ever be active without a processor grant.
REQ-023 SNOOP_GNT: the snoop grant SHALL be held while its request is high; on release it SHALL drop and the FSM SHALL return to PROC_GNT.
REQ-024 SNOOP_GNT: if the processor request drops, both grants SHALL drop at the same edge and the FSM SHALL go to IDLE, which aborts the snoop.
REQ-025 At most one Com_Bus_Gnt_proc bit and at most one snoop grant, counting Mem_snoop_gnt, SHALL be high in any cycle.
REQ-026 A hold counter SHALL count cycles of the current processor grant, saturating at MAX_HOLD.
REQ-027 When the count reaches MAX_HOLD, Hold_timeout SHALL set, the processor and snoop grants SHALL be forcibly dropped, p SHALL advance per REQ-018, and the FSM SHALL go to IDLE.
REQ-028 Hold_timeout SHALL stay set until reset.
REQ-029 If the granted request is still high after a forced drop, it SHALL compete normally in round-robin.
REQ-030 Bus_busy SHALL equal the OR of Com_Bus_Gnt_proc.
REQ-031 Gnt_id_proc SHALL be registered together with the grant.

Reset
REQ-032 While rst_n is low at an edge, all grants, Bus_busy, Gnt_id_proc, Hold_timeout and the hold counter SHALL be 0, both pointers SHALL be 0, and the FSM SHALL be in IDLE.
REQ-033 Reset SHALL take priority mid-transaction: grants SHALL drop at the reset edge, and the first grant after release SHALL come no earlier than 1 cycle after the first edge with rst_n high.

Structure
REQ-034 Package cache_arb_pkg SHALL hold the FSM state enum and the default constants for CORES and MAX_HOLD.
REQ-035 Sub-module rr_arbiter SHALL be parametrised by N, take a request vector and pointer, and return a one-hot winner plus index.
REQ-036 rr_arbiter SHALL be instantiated twice, once for processor and once for snoop arbitration.

Verification
REQ-037 Reset, then assert Com_Bus_Req_proc=8'h05 -> Gnt=8'h01 one cycle later; release bit 0 -> grant drops, bubble, Gnt=8'h04.
REQ-038 Hold all 8 requests high; release each grant after 3 cycles -> grant order 0,1,...,7,0 with wrap-around.
REQ-039 Proc grant on index 3; assert Com_Bus_Req_snoop=4'b0010 and Mem_snoop_req=1 together -> Com_Bus_Gnt_snoop=4'b0010 first, then Mem_snoop_gnt after release.
REQ-040 Assert snoop request in IDLE -> no snoop grant; drop the proc request during SNOOP_GNT -> both grants 0 at the same edge.
REQ-041 MAX_HOLD=4 with a stuck request on index 2 and a request on index 5 -> after 4 grant cycles Hold_timeout=1, then a bubble, then index 5 granted.
REQ-042 Pull rst_n low during SNOOP_GNT -> all outputs 0 at that edge, and the pointers restart at 0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// ============================================================================
// Module : cache_arb_pkg
// Brief  : Shared FSM state type and default sizing for the common-bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_arb_pkg;

    localparam int DEF_CORES    = 4;
    localparam int DEF_MAX_HOLD = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PROC_GNT  = 2'd1,
        ST_SNOOP_GNT = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick; search starts at ptr_i and wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o               = 1'b1;
                idx_o                 = cand[IW-1:0];
                gnt_o[cand[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/com_bus_arbiter.sv
// ============================================================================
// Module : com_bus_arbiter
// Brief  : Common-bus arbiter: round-robin IL/DL processor grants with nested
//          snoop grants and a processor hold-time watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module com_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int CORES    = DEF_CORES,
    parameter int NPROC    = 2 * CORES,
    parameter int NSNOOP   = CORES + 1,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPROC-1:0]         Com_Bus_Req_proc,
    output logic [NPROC-1:0]         Com_Bus_Gnt_proc,
    input  logic [CORES-1:0]         Com_Bus_Req_snoop,
    input  logic                     Mem_snoop_req,
    output logic [CORES-1:0]         Com_Bus_Gnt_snoop,
    output logic                     Mem_snoop_gnt,
    output logic [$clog2(NPROC)-1:0] Gnt_id_proc,
    output logic                     Bus_busy,
    output logic                     Hold_timeout
);

    localparam int PIW = $clog2(NPROC);
    localparam int SIW = $clog2(NSNOOP);
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [PIW-1:0] PROC_LAST = PIW'(NPROC - 1);
    localparam logic [SIW-1:0] SNP_LAST  = SIW'(NSNOOP - 1);

    arb_state_e       state_q, state_d;
    logic [NPROC-1:0] gnt_proc_q, gnt_proc_d;
    logic [PIW-1:0]   gnt_id_q, gnt_id_d;
    logic [NSNOOP-1:0] gnt_snoop_q, gnt_snoop_d;
    logic [SIW-1:0]   snoop_id_q, snoop_id_d;
    logic [PIW-1:0]   pptr_q, pptr_d;
    logic [SIW-1:0]   sptr_q, sptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [NSNOOP-1:0] snoop_req;
    logic [NPROC-1:0]  proc_win;
    logic [PIW-1:0]    proc_idx;
    logic              proc_valid;
    logic [NSNOOP-1:0] snoop_win;
    logic [SIW-1:0]    snoop_idx;
    logic              snoop_valid;
    logic              cur_req;
    logic              cur_snoop;
    logic [PIW-1:0]    pptr_next;
    logic [SIW-1:0]    sptr_next;

    // Memory is the highest snoop index, above the per-core requests.
    assign snoop_req = {Mem_snoop_req, Com_Bus_Req_snoop};
    assign cur_req   = |(Com_Bus_Req_proc & gnt_proc_q);
    assign cur_snoop = |(snoop_req & gnt_snoop_q);
    assign pptr_next = (gnt_id_q == PROC_LAST) ? '0 : gnt_id_q + 1'b1;
    assign sptr_next = (snoop_id_q == SNP_LAST) ? '0 : snoop_id_q + 1'b1;

    rr_arbiter #(.N(NPROC), .IW(PIW)) u_proc_rr (
        .req_i   (Com_Bus_Req_proc),
        .ptr_i   (pptr_q),
        .gnt_o   (proc_win),
        .idx_o   (proc_idx),
        .valid_o (proc_valid)
    );

    rr_arbiter #(.N(NSNOOP), .IW(SIW)) u_snoop_rr (
        .req_i   (snoop_req),
        .ptr_i   (sptr_q),
        .gnt_o   (snoop_win),
        .idx_o   (snoop_idx),
        .valid_o (snoop_valid)
    );

    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_id_d    = gnt_id_q;
        gnt_snoop_d = gnt_snoop_q;
        snoop_id_d  = snoop_id_q;
        pptr_d      = pptr_q;
        sptr_d      = sptr_q;
        hold_d      = hold_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (proc_valid) begin
                    state_d    = ST_PROC_GNT;
                    gnt_proc_d = proc_win;
                    gnt_id_d   = proc_idx;
                    hold_d     = HW'(1);
                end
            end
            ST_PROC_GNT, ST_SNOOP_GNT: begin
                // A holder still requesting after MAX_HOLD cycles is evicted.
                if (!cur_req || hold_q == HOLD_MAX) begin
                    state_d    = ST_IDLE;
                    gnt_proc_d = '0;
                    gnt_id_d   = '0;
                    hold_d     = '0;
                    pptr_d     = pptr_next;
                    if (cur_req) begin
                        timeout_d = 1'b1;
                    end
                    if (state_q == ST_SNOOP_GNT) begin
                        gnt_snoop_d = '0;
                        snoop_id_d  = '0;
                        sptr_d      = sptr_next;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                    if (state_q == ST_PROC_GNT) begin
                        if (snoop_valid) begin
                            state_d     = ST_SNOOP_GNT;
                            gnt_snoop_d = snoop_win;
                            snoop_id_d  = snoop_idx;
                        end
                    end else if (!cur_snoop) begin
                        state_d     = ST_PROC_GNT;
                        gnt_snoop_d = '0;
                        snoop_id_d  = '0;
                        sptr_d      = sptr_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_proc_q  <= '0;
            gnt_id_q    <= '0;
            gnt_snoop_q <= '0;
            snoop_id_q  <= '0;
            pptr_q      <= '0;
            sptr_q      <= '0;
            hold_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_id_q    <= gnt_id_d;
            gnt_snoop_q <= gnt_snoop_d;
            snoop_id_q  <= snoop_id_d;
            pptr_q      <= pptr_d;
            sptr_q      <= sptr_d;
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_q;
    assign Gnt_id_proc       = gnt_id_q;
    assign Com_Bus_Gnt_snoop = gnt_snoop_q[CORES-1:0];
    assign Mem_snoop_gnt     = gnt_snoop_q[NSNOOP-1];
    assign Bus_busy          = |gnt_proc_q;
    assign Hold_timeout      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_com_bus_arbiter.sv
// ============================================================================
// Module : tb_com_bus_arbiter
// Brief  : Directed and randomized checks of com_bus_arbiter (4 cores, hold 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_com_bus_arbiter;

    localparam int CORES  = 4;
    localparam int NPROC  = 8;
    localparam int NSNOOP = 5;
    localparam int MAXH   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_proc;
    logic [3:0] req_snoop;
    logic       mem_req;
    logic [7:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       mem_gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the bus, who owns the snoop bus, pointers.
    int m_owner  = -1;
    int m_sowner = -1;
    int m_pp     = 0;
    int m_sp     = 0;
    int m_held   = 0;
    bit m_to     = 1'b0;

    com_bus_arbiter #(
        .CORES    (CORES),
        .NPROC    (NPROC),
        .NSNOOP   (NSNOOP),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Mem_snoop_req     (mem_req),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_gnt     (mem_gnt),
        .Gnt_id_proc       (gnt_id),
        .Bus_busy          (busy),
        .Hold_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [4:0] sreq;
        int idx;
        sreq = {mem_req, req_snoop};
        if (!rst_n) begin
            m_owner = -1; m_sowner = -1; m_pp = 0; m_sp = 0; m_held = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NPROC; k++) begin
                idx = (m_pp + k) % NPROC;
                if (m_owner < 0 && req_proc[idx]) begin
                    m_owner = idx;
                    m_held  = 1;
                end
            end
        end else if (!req_proc[m_owner] || m_held == MAXH) begin
            if (req_proc[m_owner]) m_to = 1'b1;
            m_pp    = (m_owner + 1) % NPROC;
            m_owner = -1;
            m_held  = 0;
            if (m_sowner >= 0) begin
                m_sp     = (m_sowner + 1) % NSNOOP;
                m_sowner = -1;
            end
        end else begin
            m_held++;
            if (m_sowner < 0) begin
                for (int k = 0; k < NSNOOP; k++) begin
                    idx = (m_sp + k) % NSNOOP;
                    if (m_sowner < 0 && sreq[idx]) m_sowner = idx;
                end
            end else if (!sreq[m_sowner]) begin
                m_sp     = (m_sowner + 1) % NSNOOP;
                m_sowner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_proc = 8'hFF; req_snoop = 4'hF; mem_req = 1'b1;
        tick(); tick();
        n_checks++; if (gnt_proc !== 8'h00) $display("FAIL reset_gnt: got %h exp 00", gnt_proc); else n_pass++;
        n_checks++; if (gnt_snoop !== 4'h0 || mem_gnt !== 1'b0) $display("FAIL reset_snoop: got %h/%b exp 0/0", gnt_snoop, mem_gnt); else n_pass++;
        n_checks++; if (gnt_id !== 3'd0 || busy !== 1'b0) $display("FAIL reset_id_busy: got %0d/%b exp 0/0", gnt_id, busy); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b exp 0", timeout); else n_pass++;
        req_proc = '0; req_snoop = '0; mem_req = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        req_proc = 8'h05;
        tick();
        n_checks++; if (gnt_proc !== 8'h01) $display("FAIL basic_first: got %h exp 01", gnt_proc); else n_pass++;
        n_checks++; if (gnt_id !== 3'd0 || busy !== 1'b1) $display("FAIL basic_id_busy: got %0d/%b exp 0/1", gnt_id, busy); else n_pass++;
        req_proc = 8'h04;
        tick();
        n_checks++; if (gnt_proc !== 8'h00 || busy !== 1'b0) $display("FAIL basic_bubble: got %h/%b exp 00/0", gnt_proc, busy); else n_pass++;
        tick();
        n_checks++; if (gnt_proc !== 8'h04 || gnt_id !== 3'd2) $display("FAIL basic_second: got %h/%0d exp 04/2", gnt_proc, gnt_id); else n_pass++;
        req_proc = 8'h00;
        tick(); tick();
    endtask

    task automatic test_rr_order();
        logic [7:0] e;
        do_reset();
        req_proc = 8'hFF;
        tick();
        for (int n = 0; n < 9; n++) begin
            e = 8'h01 << (n % 8);
            n_checks++; if (gnt_proc !== e || gnt_id !== 3'(n % 8)) $display("FAIL rr_order[%0d]: got %h/%0d exp %h/%0d", n, gnt_proc, gnt_id, e, n % 8); else n_pass++;
            tick(); tick();
            req_proc = 8'hFF & ~e;
            tick();
            n_checks++; if (gnt_proc !== 8'h00) $display("FAIL rr_release[%0d]: got %h exp 00", n, gnt_proc); else n_pass++;
            req_proc = 8'hFF;
            tick();
        end
        req_proc = 8'h00;
        tick(); tick();
    endtask

    task automatic test_snoop();
        do_reset();
        req_proc = 8'h08;
        tick();
        n_checks++; if (gnt_proc !== 8'h08 || gnt_id !== 3'd3) $display("FAIL snoop_proc: got %h/%0d exp 08/3", gnt_proc, gnt_id); else n_pass++;
        req_snoop = 4'b0010; mem_req = 1'b1;
        tick();
        n_checks++; if (gnt_snoop !== 4'b0010 || mem_gnt !== 1'b0) $display("FAIL snoop_core: got %b/%b exp 0010/0", gnt_snoop, mem_gnt); else n_pass++;
        req_snoop = 4'b0000;
        tick();
        n_checks++; if (gnt_snoop !== 4'b0000 || mem_gnt !== 1'b0 || gnt_proc !== 8'h08) $display("FAIL snoop_release: got %b/%b/%h exp 0000/0/08", gnt_snoop, mem_gnt, gnt_proc); else n_pass++;
        tick();
        n_checks++; if (mem_gnt !== 1'b1 || gnt_snoop !== 4'b0000) $display("FAIL snoop_mem: got %b/%b exp 1/0000", mem_gnt, gnt_snoop); else n_pass++;
        req_proc = 8'h00;
        tick();
        n_checks++; if (gnt_proc !== 8'h00 || mem_gnt !== 1'b0) $display("FAIL snoop_abort_mem: got %h/%b exp 00/0", gnt_proc, mem_gnt); else n_pass++;
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_snoop_idle_abort();
        do_reset();
        req_snoop = 4'hF; mem_req = 1'b1;
        tick(); tick();
        n_checks++; if (gnt_snoop !== 4'h0 || mem_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL idle_snoop: got %b/%b/%b exp 0000/0/0", gnt_snoop, mem_gnt, busy); else n_pass++;
        req_proc = 8'h02;
        tick();
        n_checks++; if (gnt_proc !== 8'h02 || gnt_snoop !== 4'h0) $display("FAIL abort_proc: got %h/%b exp 02/0000", gnt_proc, gnt_snoop); else n_pass++;
        tick();
        n_checks++; if (gnt_snoop !== 4'b0001 || mem_gnt !== 1'b0) $display("FAIL abort_snoop_gnt: got %b/%b exp 0001/0", gnt_snoop, mem_gnt); else n_pass++;
        req_proc = 8'h00;
        tick();
        n_checks++; if (gnt_proc !== 8'h00 || gnt_snoop !== 4'h0 || mem_gnt !== 1'b0) $display("FAIL abort_both: got %h/%b/%b exp 00/0000/0", gnt_proc, gnt_snoop, mem_gnt); else n_pass++;
        req_snoop = 4'h0; mem_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req_proc = 8'h24;
        tick();
        n_checks++; if (gnt_proc !== 8'h04) $display("FAIL to_first: got %h exp 04", gnt_proc); else n_pass++;
        for (int n = 0; n < MAXH - 1; n++) begin
            tick();
            n_checks++; if (gnt_proc !== 8'h04 || timeout !== 1'b0) $display("FAIL to_hold[%0d]: got %h/%b exp 04/0", n, gnt_proc, timeout); else n_pass++;
        end
        tick();
        n_checks++; if (gnt_proc !== 8'h00 || timeout !== 1'b1) $display("FAIL to_drop: got %h/%b exp 00/1", gnt_proc, timeout); else n_pass++;
        tick();
        n_checks++; if (gnt_proc !== 8'h20 || gnt_id !== 3'd5) $display("FAIL to_next: got %h/%0d exp 20/5", gnt_proc, gnt_id); else n_pass++;
        req_proc = 8'h00;
        tick(); tick();
        n_checks++; if (timeout !== 1'b1) $display("FAIL to_sticky: got %b exp 1", timeout); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_proc = 8'h08; tick();
        req_proc = 8'h00; tick();
        req_proc = 8'h08; tick();
        n_checks++; if (gnt_proc !== 8'h08) $display("FAIL mid_regrant: got %h exp 08", gnt_proc); else n_pass++;
        req_snoop = 4'b0100; tick();
        req_snoop = 4'b0000; tick();
        req_snoop = 4'b0100; tick();
        n_checks++; if (gnt_snoop !== 4'b0100) $display("FAIL mid_snoop: got %b exp 0100", gnt_snoop); else n_pass++;
        rst_n = 1'b0; req_proc = 8'h18; req_snoop = 4'b1100;
        tick();
        n_checks++; if (gnt_proc !== 8'h00 || gnt_snoop !== 4'h0 || mem_gnt !== 1'b0 || busy !== 1'b0 || gnt_id !== 3'd0 || timeout !== 1'b0)
            $display("FAIL mid_reset_zero: got %h/%b/%b/%b/%0d/%b exp all 0", gnt_proc, gnt_snoop, mem_gnt, busy, gnt_id, timeout); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt_proc !== 8'h08 || gnt_id !== 3'd3) $display("FAIL mid_pptr: got %h/%0d exp 08/3", gnt_proc, gnt_id); else n_pass++;
        tick();
        n_checks++; if (gnt_snoop !== 4'b0100) $display("FAIL mid_sptr: got %b exp 0100", gnt_snoop); else n_pass++;
        req_proc = 8'h00; req_snoop = 4'h0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e_gp;
        logic [4:0] e_gs;
        logic [2:0] e_id;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NPROC; b++)
                if ($urandom_range(3) == 0) req_proc[b] = ~req_proc[b];
            for (int b = 0; b < CORES; b++)
                if ($urandom_range(3) == 0) req_snoop[b] = ~req_snoop[b];
            if ($urandom_range(3) == 0) mem_req = ~mem_req;
            rst_n = ($urandom_range(99) != 0);
            tick();
            e_gp = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            e_id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            e_gs = (m_sowner >= 0) ? 5'(1 << m_sowner) : 5'h00;
            n_checks++; if (gnt_proc !== e_gp) $display("FAIL rnd_gnt[%0d]: got %h exp %h", c, gnt_proc, e_gp); else n_pass++;
            n_checks++; if (gnt_id !== e_id || busy !== (m_owner >= 0)) $display("FAIL rnd_id_busy[%0d]: got %0d/%b exp %0d/%b", c, gnt_id, busy, e_id, m_owner >= 0); else n_pass++;
            n_checks++; if ({mem_gnt, gnt_snoop} !== e_gs) $display("FAIL rnd_snoop[%0d]: got %b exp %b", c, {mem_gnt, gnt_snoop}, e_gs); else n_pass++;
            n_checks++; if (timeout !== m_to) $display("FAIL rnd_timeout[%0d]: got %b exp %b", c, timeout, m_to); else n_pass++;
            n_checks++; if ($countones(gnt_proc) > 1 || $countones({mem_gnt, gnt_snoop}) > 1 || (busy === 1'b0 && {mem_gnt, gnt_snoop} !== 5'h0))
                $display("FAIL rnd_exclusive[%0d]: got %h/%b exp onehot0, no snoop when idle", c, gnt_proc, {mem_gnt, gnt_snoop}); else n_pass++;
        end
        rst_n = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
        test_reset();
        test_basic();
        test_rr_order();
        test_snoop();
        test_snoop_idle_abort();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
